victim_buffer: RTL

VICTIM_BUFFER -- requirements
Module: victim_buffer

---
 rtl/victim_buffer_pkg.sv | 23 ++
 rtl/victim_line_reg.sv | 31 +++
 rtl/victim_buffer.sv | 108 ++++++++++
 3 files changed

// File: rtl/victim_buffer_pkg.sv
// Shared LC-3b types for the victim buffer: bus widths, FSM state enum
// and the line-alignment helper.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_datbus;

  typedef enum logic [1:0] {
    VB_IDLE  = 2'd0,
    VB_FETCH = 2'd1,
    VB_DRAIN = 2'd2
  } lc3b_vb_state;

  function automatic lc3b_word line_align(
    input lc3b_word    a,
    input int unsigned ob
  );
    lc3b_word m;
    m = lc3b_word'((32'd1 << ob) - 32'd1);
    return a & ~m;
  endfunction

endpackage

// File: rtl/victim_line_reg.sv
// Single victim-line entry: valid bit, line address and line data,
// with load (capture) and clear (drain done) controls.
import lc3b_types::*;

module victim_line_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  lc3b_word   load_addr,
  input  lc3b_datbus load_data,
  output logic       valid,
  output lc3b_word   addr,
  output lc3b_datbus data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/victim_buffer.sv
// One-entry victim buffer between L1 cache and physical memory.
// Optional VICTIM_BUFFER_READ_HIT_EN serves reads from the buffered line.
import lc3b_types::*;

module victim_buffer #(
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c_read,
  input  logic       c_write,
  input  lc3b_word   c_address,
  input  lc3b_datbus c_wdata,
  output lc3b_datbus c_rdata,
  output logic       c_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  output lc3b_word   pmem_address,
  output lc3b_datbus pmem_wdata,
  input  lc3b_datbus pmem_rdata,
  input  logic       pmem_resp
);

  lc3b_vb_state state;
  lc3b_word     fetch_addr;
  lc3b_word     line_addr;
  logic         vb_valid;
  lc3b_word     vb_addr;
  lc3b_datbus   vb_data;
  logic         vb_clear;
  logic         accept;
  logic         wr_go;
  logic         rd_go;
  logic         hit;

  assign line_addr = line_align(c_address, OFFSET_BITS);

  // c_resp high means the cache still holds the request just served
  assign accept = !c_resp && (state != VB_FETCH);

`ifdef VICTIM_BUFFER_READ_HIT_EN
  assign hit = accept && c_read && !c_write && vb_valid
             && (vb_addr == line_addr);
`else
  assign hit = 1'b0;
`endif

  assign wr_go = accept && (state == VB_IDLE)
               && c_write && !vb_valid;
  assign rd_go = accept && (state == VB_IDLE)
               && c_read && !c_write && !hit;
  assign vb_clear = (state == VB_DRAIN) && pmem_resp;

  victim_line_reg u_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (wr_go),
    .clear     (vb_clear),
    .load_addr (line_addr),
    .load_data (c_wdata),
    .valid     (vb_valid),
    .addr      (vb_addr),
    .data      (vb_data)
  );

  assign pmem_read    = (state == VB_FETCH);
  assign pmem_write   = (state == VB_DRAIN);
  assign pmem_address = (state == VB_DRAIN) ? vb_addr : fetch_addr;
  assign pmem_wdata   = vb_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= VB_IDLE;
      c_resp     <= 1'b0;
      c_rdata    <= '0;
      fetch_addr <= '0;
    end else begin
      c_resp <= 1'b0;
      unique case (state)
        VB_IDLE: begin
          if (wr_go) begin
            c_resp <= 1'b1;
            state  <= VB_DRAIN;
          end else if (rd_go) begin
            fetch_addr <= line_addr;
            state      <= VB_FETCH;
          end
        end
        VB_FETCH: begin
          if (pmem_resp) begin
            c_rdata <= pmem_rdata;
            c_resp  <= 1'b1;
            state   <= VB_IDLE;
          end
        end
        VB_DRAIN: begin
          if (pmem_resp) state <= VB_IDLE;
        end
        default: state <= VB_IDLE;
      endcase
      if (hit) begin
        c_rdata <= vb_data;
        c_resp  <= 1'b1;
      end
    end
  end

endmodule
